ma_threshold_detector: RTL and testbench
========================================

// Module: ma_threshold_detector
// PURPOSE
//  Consumes the moving-average output stream: 10-bit sample plus strobe.
//  Sits directly downstream of the moving averager.
//  Classifies the filtered signal against hysteresis thresholds with a consecutive-sample
//  debounce, and emits a level flag plus one-cycle rise/fall events.
//  Also tracks the peak sample and counts rise events for readout.
// PARAMETERS
//  DATA_W    10  sample / threshold / peak width
//  DEBOUNCE  4   consecutive qualifying samples needed to change state (1..7)
//  EVT_W     8   width of the saturating rise-event counter
// PORTS
//  clk         in   1       system clock; all logic on rising edge
//  rst         in   1       asynchronous, active-high reset
//  data_in     in   DATA_W  filtered sample from the moving averager (unsigned)
//  strobe_in   in   1       sample strobe; a sample is taken on each 0->1 transition
//  thr_hi      in   DATA_W  upper threshold (unsigned)
//  thr_lo      in   DATA_W  lower threshold (unsigned)
//  clear_peak  in   1       synchronous clear of the peak register
//  above       out  1       level: signal classified as high
//  rise_evt    out  1       one-cycle pulse on the low->high classification
//  fall_evt    out  1       one-cycle pulse on the high->low classification
//  peak        out  DATA_W  max accepted sample since reset / clear_peak
//  event_cnt   out  EVT_W   number of rise events, saturating at 2^EVT_W-1
//  strobe_out  out  1       one-cycle pulse: outputs updated for a new sample
// BEHAVIOUR
//  Reset: all outputs 0; FSM=BELOW; debounce cnt=0; strobe_q=1.
//   strobe_q resets to 1 so a strobe already high at reset release is not accepted.
//  Accept: at edge k, strobe_in=1 and strobe_q=0. data_in is sampled at edge k, and
//   the FSM, peak and event_cnt update at edge k. strobe_out is high for the cycle
//   after edge k only. Strobe held high accepts exactly one sample.
//  Without an accept, no state changes. Exception: clear_peak.
//  FSM, evaluated only on accept (d=data_in, n=debounce cnt):
//   BELOW:  d>=thr_hi -> n=1.
//           If DEBOUNCE==1: go ABOVE, pulse rise_evt. Else go ARM_HI.
//   ARM_HI: d>=thr_hi -> n=n+1. At n==DEBOUNCE: go ABOVE, pulse rise_evt, n=0.
//           d<thr_hi  -> go BELOW, n=0.
//   ABOVE:  d<=thr_lo -> n=1.
//           If DEBOUNCE==1: go BELOW, pulse fall_evt. Else go ARM_LO.
//   ARM_LO: d<=thr_lo -> n=n+1. At n==DEBOUNCE: go BELOW, pulse fall_evt, n=0.
//           d>thr_lo  -> go ABOVE, n=0.
//  above = (state==ABOVE || state==ARM_LO); registered.
//  rise_evt/fall_evt: high for the single cycle after the transitioning edge;
//   coincide with strobe_out.
//  Comparisons are unsigned, full DATA_W.
//  thr_lo>=thr_hi is legal; the rules above still apply literally (no special case).
//  Thresholds are sampled only at accept edges; changing them between samples is safe.
//  peak: on accept, peak <= max(peak, d).
//   clear_peak without accept -> peak=0.
//   clear_peak with accept -> peak=d; the clear wins over the old value.
//  event_cnt: +1 on each rise transition; holds at all-ones (no wrap).
//  Reset asserted mid-debounce or mid-pulse: everything returns to reset values
//   immediately (async); a pending transition is discarded.
// TESTING  (DEBOUNCE=4, thr_hi=600, thr_lo=400)
//  1 Reset with strobe_in=1, release, hold strobe high 20 clks.
//    -> no strobe_out; all outputs stay 0.
//  2 Four samples of 1023 after zeros -> rise_evt and strobe_out together on the 4th
//    sample; above=1, peak=1023, event_cnt=1.
//  3 Three samples of 1023, then 0 -> no rise_evt; above stays 0; peak=1023.
//  4 Reach ABOVE, then ten samples of 500 -> above stays 1.
//    Then four samples of 400 -> fall_evt on the 4th; above=0.
//  5 peak=900, clear_peak asserted on the same edge as accepting 300 -> peak=300.
//    clear_peak alone -> peak=0.
//  6 260 debounced rise/fall cycles -> event_cnt ends at 255 (saturated, no wrap).

Source files
------------

// File: rtl/ma_threshold_detector.sv
// Hysteresis threshold detector for the moving-average stream: debounced level flag,
// rise/fall event pulses, peak tracking and a saturating rise-event counter.
module ma_threshold_detector #(
    parameter int DATA_W   = 10,
    parameter int DEBOUNCE = 4,
    parameter int EVT_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              strobe_in,
    input  logic [DATA_W-1:0] thr_hi,
    input  logic [DATA_W-1:0] thr_lo,
    input  logic              clear_peak,
    output logic              above,
    output logic              rise_evt,
    output logic              fall_evt,
    output logic [DATA_W-1:0] peak,
    output logic [EVT_W-1:0]  event_cnt,
    output logic              strobe_out
);

    typedef enum logic [1:0] {
        ST_BELOW  = 2'd0,
        ST_ARM_HI = 2'd1,
        ST_ABOVE  = 2'd2,
        ST_ARM_LO = 2'd3
    } state_t;

    localparam logic [2:0] DEB = 3'(DEBOUNCE);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [2:0] r_cnt;
    logic [2:0] w_cnt_nxt;
    logic [2:0] w_cnt_inc;
    logic       r_strobe_q;
    logic       w_accept;
    logic       w_rise;
    logic       w_fall;
    logic       w_above_nxt;

    assign w_accept  = strobe_in & ~r_strobe_q;
    assign w_cnt_inc = r_cnt + 3'd1;

    // State and debounce count only move on an accepted sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_BELOW;
            r_cnt   <= 3'd0;
        end else if (w_accept) begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_BELOW: begin
                if (data_in >= thr_hi) begin
                    if (DEBOUNCE == 1) begin
                        w_state_nxt = ST_ABOVE;
                        w_cnt_nxt   = 3'd0;
                    end else begin
                        w_state_nxt = ST_ARM_HI;
                        w_cnt_nxt   = 3'd1;
                    end
                end
            end
            ST_ARM_HI: begin
                if (data_in >= thr_hi) begin
                    if (w_cnt_inc == DEB) begin
                        w_state_nxt = ST_ABOVE;
                        w_cnt_nxt   = 3'd0;
                    end else begin
                        w_cnt_nxt   = w_cnt_inc;
                    end
                end else begin
                    w_state_nxt = ST_BELOW;
                    w_cnt_nxt   = 3'd0;
                end
            end
            ST_ABOVE: begin
                if (data_in <= thr_lo) begin
                    if (DEBOUNCE == 1) begin
                        w_state_nxt = ST_BELOW;
                        w_cnt_nxt   = 3'd0;
                    end else begin
                        w_state_nxt = ST_ARM_LO;
                        w_cnt_nxt   = 3'd1;
                    end
                end
            end
            ST_ARM_LO: begin
                if (data_in <= thr_lo) begin
                    if (w_cnt_inc == DEB) begin
                        w_state_nxt = ST_BELOW;
                        w_cnt_nxt   = 3'd0;
                    end else begin
                        w_cnt_nxt   = w_cnt_inc;
                    end
                end else begin
                    w_state_nxt = ST_ABOVE;
                    w_cnt_nxt   = 3'd0;
                end
            end
            default: begin
                w_state_nxt = ST_BELOW;
                w_cnt_nxt   = 3'd0;
            end
        endcase
    end

    always_comb begin
        w_rise      = 1'b0;
        w_fall      = 1'b0;
        w_above_nxt = (w_state_nxt == ST_ABOVE) || (w_state_nxt == ST_ARM_LO);
        if ((r_state == ST_BELOW || r_state == ST_ARM_HI) && w_state_nxt == ST_ABOVE)
            w_rise = 1'b1;
        if ((r_state == ST_ABOVE || r_state == ST_ARM_LO) && w_state_nxt == ST_BELOW)
            w_fall = 1'b1;
    end

    // Strobe history resets high so a strobe already asserted at reset release is ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_strobe_q <= 1'b1;
            strobe_out <= 1'b0;
            rise_evt   <= 1'b0;
            fall_evt   <= 1'b0;
            above      <= 1'b0;
        end else begin
            r_strobe_q <= strobe_in;
            strobe_out <= w_accept;
            rise_evt   <= w_accept & w_rise;
            fall_evt   <= w_accept & w_fall;
            if (w_accept)
                above <= w_above_nxt;
        end
    end

    // A clear coinciding with an accept discards the old peak in favour of the new sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            peak <= '0;
        end else if (w_accept) begin
            if (clear_peak || (data_in > peak))
                peak <= data_in;
        end else if (clear_peak) begin
            peak <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            event_cnt <= '0;
        end else if (w_accept && w_rise && (event_cnt != '1)) begin
            event_cnt <= event_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_ma_threshold_detector.sv
// Directed bench for ma_threshold_detector: a vector table for single-sample behaviour
// plus hand sequences for reset, held strobe, peak clear and counter saturation.
module tb_ma_threshold_detector;

    localparam int DW = 10;
    localparam int EW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] data_in;
    logic          strobe_in;
    logic [DW-1:0] thr_hi;
    logic [DW-1:0] thr_lo;
    logic          clear_peak;
    logic          above;
    logic          rise_evt;
    logic          fall_evt;
    logic [DW-1:0] peak;
    logic [EW-1:0] event_cnt;
    logic          strobe_out;

    int nChecks = 0;
    int nFails  = 0;

    ma_threshold_detector #(.DATA_W(DW), .DEBOUNCE(4), .EVT_W(EW)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .strobe_in  (strobe_in),
        .thr_hi     (thr_hi),
        .thr_lo     (thr_lo),
        .clear_peak (clear_peak),
        .above      (above),
        .rise_evt   (rise_evt),
        .fall_evt   (fall_evt),
        .peak       (peak),
        .event_cnt  (event_cnt),
        .strobe_out (strobe_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic          clr;
        logic          expAbove;
        logic          expRise;
        logic          expFall;
        logic [DW-1:0] expPeak;
        logic [EW-1:0] expCnt;
    } vec_t;

    vec_t vecs[$];

    function automatic void addVec(input logic [DW-1:0] d, input logic c, input logic a,
                                   input logic r, input logic f, input logic [DW-1:0] p,
                                   input logic [EW-1:0] n);
        vec_t v;
        v.data = d; v.clr = c; v.expAbove = a; v.expRise = r; v.expFall = f;
        v.expPeak = p; v.expCnt = n;
        vecs.push_back(v);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // One accepted sample; returns at the negedge where strobe_out should be high.
    task automatic applyStimulus(input logic [DW-1:0] d, input logic c);
        @(negedge clk);
        data_in    = d;
        clear_peak = c;
        strobe_in  = 1'b1;
        @(negedge clk);
        clear_peak = 1'b0;
        strobe_in  = 1'b0;
    endtask

    task automatic checkAll(input string tag, input logic so, input logic a, input logic r,
                            input logic f, input logic [DW-1:0] p, input logic [EW-1:0] n);
        checkOutput({tag, ".strobe_out"}, 32'(strobe_out), 32'(so));
        checkOutput({tag, ".above"},      32'(above),      32'(a));
        checkOutput({tag, ".rise_evt"},   32'(rise_evt),   32'(r));
        checkOutput({tag, ".fall_evt"},   32'(fall_evt),   32'(f));
        checkOutput({tag, ".peak"},       32'(peak),       32'(p));
        checkOutput({tag, ".event_cnt"},  32'(event_cnt),  32'(n));
    endtask

    initial begin : main
        logic [EW-1:0] expCnt;

        rst = 1'b1; strobe_in = 1'b1; data_in = 10'd1023; clear_peak = 1'b0;
        thr_hi = 10'd600; thr_lo = 10'd400;

        // Test 2 / 4 / 3 as a continuous table from reset.
        addVec(10'd0, 0, 0, 0, 0, 10'd0, 8'd0);
        for (int i = 0; i < 3; i++) addVec(10'd1023, 0, 0, 0, 0, 10'd1023, 8'd0);
        addVec(10'd1023, 0, 1, 1, 0, 10'd1023, 8'd1);
        for (int i = 0; i < 10; i++) addVec(10'd500, 0, 1, 0, 0, 10'd1023, 8'd1);
        for (int i = 0; i < 3; i++) addVec(10'd400, 0, 1, 0, 0, 10'd1023, 8'd1);
        addVec(10'd400, 0, 0, 0, 1, 10'd1023, 8'd1);
        for (int i = 0; i < 3; i++) addVec(10'd1023, 0, 0, 0, 0, 10'd1023, 8'd1);
        addVec(10'd0, 0, 0, 0, 0, 10'd1023, 8'd1);

        // Test 1: strobe high through reset release must not be accepted.
        repeat (3) @(negedge clk);
        checkAll("reset", 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 8'd0);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checkOutput("heldStrobe.strobe_out", 32'(strobe_out), 32'd0);
            checkOutput("heldStrobe.peak", 32'(peak), 32'd0);
        end
        checkAll("heldStrobeEnd", 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 8'd0);
        strobe_in = 1'b0;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].data, vecs[i].clr);
            checkAll($sformatf("vec%0d", i), 1'b1, vecs[i].expAbove, vecs[i].expRise,
                     vecs[i].expFall, vecs[i].expPeak, vecs[i].expCnt);
            @(negedge clk);
            checkOutput($sformatf("vec%0d.pulseEnd", i), 32'(strobe_out), 32'd0);
        end

        // Test 5: peak clear alone and coincident with an accept.
        @(negedge clk); clear_peak = 1'b1;
        @(negedge clk); clear_peak = 1'b0;
        checkAll("clearAlone1", 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 8'd1);
        applyStimulus(10'd900, 1'b0);
        checkAll("peak900", 1'b1, 1'b0, 1'b0, 1'b0, 10'd900, 8'd1);
        applyStimulus(10'd300, 1'b1);
        checkAll("clearWithAccept", 1'b1, 1'b0, 1'b0, 1'b0, 10'd300, 8'd1);
        @(negedge clk); clear_peak = 1'b1;
        @(negedge clk); clear_peak = 1'b0;
        checkAll("clearAlone2", 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 8'd1);

        // Test 6: 260 debounced rise/fall cycles saturate the counter at 255.
        expCnt = 8'd1;
        for (int k = 0; k < 260; k++) begin
            for (int j = 0; j < 4; j++) applyStimulus(10'd1023, 1'b0);
            if (expCnt != 8'd255) expCnt = expCnt + 8'd1;
            checkOutput($sformatf("sat%0d.rise_evt", k), 32'(rise_evt), 32'd1);
            checkOutput($sformatf("sat%0d.event_cnt", k), 32'(event_cnt), 32'(expCnt));
            for (int j = 0; j < 4; j++) applyStimulus(10'd0, 1'b0);
            checkOutput($sformatf("sat%0d.fall_evt", k), 32'(fall_evt), 32'd1);
        end
        checkAll("satEnd", 1'b1, 1'b0, 1'b0, 1'b1, 10'd1023, 8'd255);

        // Async reset mid-debounce discards the pending rise.
        applyStimulus(10'd1023, 1'b0);
        applyStimulus(10'd1023, 1'b0);
        #2 rst = 1'b1;
        #1 checkAll("asyncReset", 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 8'd0);
        @(negedge clk); rst = 1'b0;
        applyStimulus(10'd1023, 1'b0);
        applyStimulus(10'd1023, 1'b0);
        checkAll("afterReset", 1'b1, 1'b0, 1'b0, 1'b0, 10'd1023, 8'd0);

        // Strobe held high for several cycles counts as a single sample.
        @(negedge clk); data_in = 10'd1023; strobe_in = 1'b1;
        @(negedge clk);
        checkOutput("hold.first", 32'(strobe_out), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("hold.more", 32'(strobe_out), 32'd0);
        end
        strobe_in = 1'b0;
        checkOutput("hold.noRise", 32'(event_cnt), 32'd0);
        applyStimulus(10'd1023, 1'b0);
        checkAll("holdPlus1", 1'b1, 1'b1, 1'b1, 1'b0, 10'd1023, 8'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
